// File: rtl/control.sv
// Greenhouse heater controller.
// Heat demand comes in from another clock domain, is synchronized and debounced,
// then drives an on/off FSM that enforces minimum on and off times and an
// over-temperature lockout with hysteresis. The heater enable is registered.
module control #(
  parameter int unsigned MIN_ON   = 8,    // minimum heater-on time, cycles (1..65535)
  parameter int unsigned MIN_OFF  = 8,    // minimum heater-off time, cycles (1..65535)
  parameter int unsigned DEBOUNCE = 3,    // stable cycles to accept a demand change (1..255)
  parameter int unsigned MAX_TEMP = 200,  // over-temperature trip threshold
  parameter int unsigned HYST     = 10    // release hysteresis below MAX_TEMP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] greenhouse_temp,
  input  logic       temp_g_greenhouse_temp,
  output logic       out
);

  typedef enum logic [2:0] {
    StOffWait,
    StOff,
    StHeatWait,
    StHeat,
    StLockout
  } state_e;

  localparam logic [7:0]  TripTemp    = 8'(MAX_TEMP);
  localparam logic [7:0]  ReleaseTemp = 8'(MAX_TEMP - HYST);
  // Counter values seen on the last cycle of each timed state.
  localparam logic [15:0] OnLast      = 16'(MIN_ON - 1);
  localparam logic [15:0] OffLast     = 16'(MIN_OFF - 1);
  localparam logic [7:0]  DbLast      = 8'(DEBOUNCE - 1);

  logic        sync_s1_q, sync_s2_q;
  logic        demand_q, demand_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic [7:0]  temp_q;
  logic        overtemp, temp_release;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        out_d;

  // Two-flop synchronizer for the asynchronous demand flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_s1_q <= 1'b0;
      sync_s2_q <= 1'b0;
    end else begin
      sync_s1_q <= temp_g_greenhouse_temp;
      sync_s2_q <= sync_s1_q;
    end
  end

  // Debounce: accept s2 only after it has differed from demand for DEBOUNCE edges in a row.
  always_comb begin
    demand_d = demand_q;
    db_cnt_d = '0;
    if (sync_s2_q != demand_q) begin
      if (db_cnt_q == DbLast) begin
        demand_d = sync_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      demand_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      demand_q <= demand_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Temperature sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp_q <= '0;
    end else begin
      temp_q <= greenhouse_temp;
    end
  end

  assign overtemp     = (temp_q >= TripTemp);
  assign temp_release = (temp_q <= ReleaseTemp);

  // Next-state decode; over-temperature wins over every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOffWait: begin
        if (overtemp) begin
          state_d = StLockout;
        end else if (cnt_q == OffLast) begin
          state_d = StOff;
        end
      end
      StOff: begin
        if (overtemp) begin
          state_d = StLockout;
        end else if (demand_q) begin
          state_d = StHeatWait;
        end
      end
      StHeatWait: begin
        // Demand is deliberately ignored here so the on time is never shortened.
        if (overtemp) begin
          state_d = StLockout;
        end else if (cnt_q == OnLast) begin
          state_d = StHeat;
        end
      end
      StHeat: begin
        if (overtemp) begin
          state_d = StLockout;
        end else if (!demand_q) begin
          state_d = StOffWait;
        end
      end
      StLockout: begin
        if (temp_release) begin
          state_d = StOffWait;
        end
      end
      default: state_d = StOffWait;
    endcase
  end

  // Dwell counter: cleared on any state change, saturates so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Heater enable follows the next state so it switches on the same edge as the FSM.
  always_comb begin
    out_d = (state_d == StHeatWait) || (state_d == StHeat);
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StOffWait;
      cnt_q   <= '0;
      out     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the greenhouse heater controller: directed latency and
// boundary scenarios with literal expectations, then a randomized run compared
// every cycle against a timestamp/history-based model.
module tb_control;

  localparam int unsigned MIN_ON   = 8;
  localparam int unsigned MIN_OFF  = 8;
  localparam int unsigned DEBOUNCE = 3;
  localparam int unsigned MAX_TEMP = 200;
  localparam int unsigned HYST     = 10;

  logic       clk;
  logic       rst;
  logic [7:0] gt;
  logic       t_g_gt;
  logic       out;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  control #(
    .MIN_ON  (MIN_ON),
    .MIN_OFF (MIN_OFF),
    .DEBOUNCE(DEBOUNCE),
    .MAX_TEMP(MAX_TEMP),
    .HYST    (HYST)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .greenhouse_temp       (gt),
    .temp_g_greenhouse_temp(t_g_gt),
    .out                   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes named after the heater phases; timing via entry timestamps, demand via
  // a history of raw input samples.
  localparam int M_OFF_WAIT = 0, M_OFF = 1, M_HEAT_WAIT = 2, M_HEAT = 3, M_LOCKOUT = 4;

  int         m_cyc = 0;
  int         m_enter = 0;
  int         m_mode = M_OFF_WAIT;
  logic       m_dem = 1'b0;
  logic [7:0] m_temp = '0;
  logic       m_out = 1'b0;
  logic       m_hist[$];   // [0] = raw input one edge ago, [1] = two edges ago, ...

  always @(posedge clk or negedge rst) begin
    int  elapsed, nxt;
    bit  hot, cool, flip;
    if (!rst) begin
      m_hist.delete();
      for (int j = 0; j <= DEBOUNCE; j++) m_hist.push_back(1'b0);
      m_dem   = 1'b0;
      m_temp  = '0;
      m_mode  = M_OFF_WAIT;
      m_enter = m_cyc;
      m_out   = 1'b0;
    end else begin
      m_cyc++;
      elapsed = m_cyc - m_enter;
      hot  = (int'(m_temp) >= MAX_TEMP);
      cool = (int'(m_temp) <= MAX_TEMP - HYST);
      nxt  = m_mode;
      if (m_mode == M_LOCKOUT) begin
        if (cool) nxt = M_OFF_WAIT;
      end else if (hot) begin
        nxt = M_LOCKOUT;
      end else begin
        case (m_mode)
          M_OFF_WAIT:  if (elapsed >= MIN_OFF) nxt = M_OFF;
          M_OFF:       if (m_dem) nxt = M_HEAT_WAIT;
          M_HEAT_WAIT: if (elapsed >= MIN_ON) nxt = M_HEAT;
          M_HEAT:      if (!m_dem) nxt = M_OFF_WAIT;
          default:     nxt = M_OFF_WAIT;
        endcase
      end
      if (nxt != m_mode) begin
        m_mode  = nxt;
        m_enter = m_cyc;
      end
      m_out = (m_mode == M_HEAT_WAIT) || (m_mode == M_HEAT);
      // Demand flips once the last DEBOUNCE synchronized samples all disagree with it.
      flip = 1;
      for (int j = 1; j <= DEBOUNCE; j++) if (m_hist[j] == m_dem) flip = 0;
      if (flip) m_dem = ~m_dem;
      m_hist.push_front(t_g_gt);
      void'(m_hist.pop_back());
      m_temp = gt;
    end
  end

  // Compare process: DUT output against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) check("out_vs_model", {31'd0, out}, {31'd0, m_out});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out equals level or limit edges pass; k = edges taken.
  task automatic edges_until(input logic level, input int limit, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (out !== level && k < limit);
  endtask

  initial begin
    int k;
    bit hi;

    rst = 1'b0; t_g_gt = 1'b0; gt = 8'd50;
    repeat (3) step();
    check("reset_out", {31'd0, out}, 32'd0);
    cmp_en = 1;

    // Demand already high at release: sync 2 + debounce 3 overlaps the 8-cycle
    // OFF_WAIT, heater comes on at edge MIN_OFF + 1.
    rst = 1'b1; t_g_gt = 1'b1;
    edges_until(1'b1, 30, k);
    check("min_off_after_reset", k, 9);
    t_g_gt = 1'b0;
    edges_until(1'b0, 40, k);
    repeat (12) step();

    // Demand rise while in OFF: out on edge 2 + DEBOUNCE + 1.
    t_g_gt = 1'b1;
    edges_until(1'b1, 30, k);
    check("demand_latency", k, 6);
    step(); step();
    t_g_gt = 1'b0;
    edges_until(1'b0, 40, k);
    // MIN_ON cycles of HEAT_WAIT plus the one HEAT cycle that sees demand gone.
    check("on_time", k + 2, 9);
    repeat (12) step();

    // Two-cycle glitch is rejected by the debouncer.
    t_g_gt = 1'b1; step(); step(); t_g_gt = 1'b0;
    hi = 0;
    repeat (15) begin step(); if (out) hi = 1; end
    check("debounce_reject", {31'd0, hi}, 32'd0);

    // Over-temperature trip from HEAT, hysteresis hold, release and resume.
    t_g_gt = 1'b1;
    edges_until(1'b1, 30, k);
    repeat (MIN_ON + 2) step();
    check("in_heat", {31'd0, out}, 32'd1);
    gt = 8'd200;
    edges_until(1'b0, 10, k);
    check("overtemp_drop", k, 2);
    gt = 8'd195;
    hi = 0;
    repeat (12) begin step(); if (out) hi = 1; end
    check("hyst_hold", {31'd0, hi}, 32'd0);
    gt = 8'd190;
    edges_until(1'b1, 40, k);
    // temp_q, LOCKOUT->OFF_WAIT, MIN_OFF cycles, then OFF->HEAT_WAIT.
    check("resume_after_release", k, 11);

    // 199 keeps heating; 200 during HEAT_WAIT trips before MIN_ON expires.
    gt = 8'd199;
    step(); step();
    check("boundary_199_on", {31'd0, out}, 32'd1);
    gt = 8'd200;
    edges_until(1'b0, 10, k);
    check("trip_in_heat_wait", k, 2);

    // Asynchronous reset while heating.
    gt = 8'd50;
    edges_until(1'b1, 40, k);
    repeat (MIN_ON + 2) step();
    check("pre_reset_heat", {31'd0, out}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_reset", {31'd0, out}, 32'd0);
    @(posedge clk); #1;
    step(); step();
    rst = 1'b1;
    edges_until(1'b1, 30, k);
    check("restart_after_reset", k, 9);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) t_g_gt = ~t_g_gt;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) gt = 8'($urandom_range(185, 205));
        else gt = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter MIN_ON, default 8: minimum heater-on time in clock cycles, legal range 1..65535.
REQ-002 Parameter MIN_OFF, default 8: minimum heater-off time in clock cycles, legal range 1..65535.
REQ-003 Parameter DEBOUNCE, default 3: consecutive stable cycles needed to accept a demand change, legal range 1..255.
REQ-004 Parameter MAX_TEMP, default 200: over-temperature trip threshold (8-bit).
REQ-005 Parameter HYST, default 10: over-temperature release hysteresis, HYST < MAX_TEMP.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port greenhouse_temp, input, 8 bits: unsigned measured greenhouse temperature.
REQ-009 Port temp_g_greenhouse_temp, input, 1 bit: setpoint greater than greenhouse temperature (heat demand), asynchronous to clk.
REQ-010 Port out, output, 1 bit: heater enable, registered, 1 = on.

Function
REQ-011 temp_g_greenhouse_temp SHALL pass through a two-flop synchronizer (s1 -> s2) before any use.
REQ-012 Filtered flag demand SHALL take the value of s2 only after s2 has differed from demand on DEBOUNCE consecutive rising edges; any intermediate return to the old value clears the 16-bit-or-smaller debounce count.
REQ-013 greenhouse_temp SHALL be registered into temp_q every cycle; overtemp = (temp_q >= MAX_TEMP); release = (temp_q <= MAX_TEMP - HYST), unsigned 8-bit compare.
REQ-014 FSM states: OFF_WAIT, OFF, HEAT_WAIT, HEAT, LOCKOUT; a 16-bit cycle counter clears on every state change.
REQ-015 OFF_WAIT: out = 0; after MIN_OFF cycles in the state -> OFF; overtemp -> LOCKOUT.
REQ-016 OFF: out = 0; overtemp -> LOCKOUT; else demand = 1 -> HEAT_WAIT.
REQ-017 HEAT_WAIT: out = 1; overtemp -> LOCKOUT immediately (overrides MIN_ON); else after MIN_ON cycles -> HEAT.
REQ-018 HEAT: out = 1; overtemp -> LOCKOUT; else demand = 0 -> OFF_WAIT.
REQ-019 LOCKOUT: out = 0; release -> OFF_WAIT; demand ignored.
REQ-020 Demand dropping during HEAT_WAIT SHALL NOT shorten the on time; transition to OFF_WAIT occurs from HEAT on the first cycle after MIN_ON expires.
REQ-021 Overtemp SHALL take priority over every other transition when evaluated in the same cycle.
REQ-022 out SHALL be a flop loaded with the next-state decode, so out changes on the same edge as the state.
REQ-023 Latency: a steady demand rise while in OFF raises out on rising edge 2 + DEBOUNCE + 1 after the input change (edge 6 with defaults).
REQ-024 Latency: greenhouse_temp reaching MAX_TEMP drops out on the 2nd rising edge after the change (temp_q, then FSM).

Reset
REQ-025 rst = 0 SHALL asynchronously force out = 0, state = OFF_WAIT, counter = 0, s1 = s2 = 0, demand = 0, debounce count = 0, temp_q = 0.
REQ-026 After rst is released, the heater SHALL NOT turn on before MIN_OFF cycles have elapsed in OFF_WAIT.
REQ-027 Reset asserted mid-operation, including in HEAT_WAIT or LOCKOUT, SHALL abort immediately with no pending transitions retained.

Verification
REQ-028 Reset: rst = 0 with out = 1 in HEAT -> out = 0 before the next clk edge; after release, out stays 0 for at least 8 cycles.
REQ-029 Demand: gt = 50, t_g_gt 0 -> 1 while in OFF -> out = 1 on the 6th edge; t_g_gt returns to 0 after 2 cycles -> out stays 1 for 8 cycles (MIN_ON), then goes to 0.
REQ-030 Debounce: t_g_gt pulsed high for 2 cycles only -> out stays 0.
REQ-031 Overtemp: in HEAT, gt = 200 -> out = 0 two edges later; gt = 195 -> out stays 0; gt = 190 -> OFF_WAIT, then after 8 cycles heating resumes if demand = 1.
REQ-032 Boundary: gt = 199 with demand = 1 -> heater on; gt = 200 during HEAT_WAIT -> LOCKOUT before MIN_ON expires.
